// File: rtl/simon_pkg.sv
// simon_pkg: shared state codes, default parameters and score/width helpers for the Simon core
package simon_pkg;
  localparam int NUM_BUTTONS_DEF = 4;
  localparam int DEPTH_DEF = 16;
  localparam int SHOW_TICKS_DEF = 2;
  localparam int GAP_TICKS_DEF = 1;
  localparam int TIMEOUT_TICKS_DEF = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXTEND = 3'd1;
  localparam logic [2:0] S_SHOW_ON = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_IN = 3'd4;
  localparam logic [2:0] S_ECHO = 3'd5;
  localparam logic [2:0] S_WIN = 3'd6;
  localparam logic [2:0] S_LOSE = 3'd7;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  // A loss in round len means len-1 rounds were completed
  function automatic int end_score(input logic won, input int len, input int depth);
    return won ? depth : len - 1;
  endfunction
endpackage

// File: rtl/simon_tick_timer.sv
// simon_tick_timer: counts time-base pulses and flags the pulse that reaches the terminal count
module simon_tick_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          pulse,
  input  logic [TW-1:0] term,
  output logic          done
);
  logic [TW-1:0] cnt;
  assign done = pulse && (cnt == term - TW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (pulse) cnt <= cnt + TW'(1);
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon game core - grows a random sequence, plays it back, checks the echo, keeps a best score
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SHOW_TICKS = SHOW_TICKS_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  localparam int BW = $clog2(NUM_BUTTONS),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [BW-1:0] IN,
  input  logic          IN_VALID,
  input  logic [BW-1:0] RAND,
  input  logic          TIMER_PULSE,
  input  logic          START,
  output logic [BW-1:0] OUT,
  output logic          OUT_ENA,
  output logic          WIN,
  output logic          LOSE,
  output logic          HS,
  output logic [LW-1:0] LEVEL,
  output logic          BUSY
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);
  logic [2:0] state, nxt;
  logic [BW-1:0] seq [DEPTH];
  logic [BW-1:0] echo_q;
  logic [LW-1:0] len, best;
  logic [IW-1:0] idx;
  logic [TW-1:0] term;
  logic start_q, start_rise, timed, done, clr, last, full, hit;
  int score;
  assign start_rise = START && !start_q;
  assign last = (LW'(idx) == len - LW'(1));
  assign full = (len == LW'(DEPTH));
  assign hit = (int'(IN) < NUM_BUTTONS) && (IN == seq[idx]);
  assign timed = state inside {S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_ECHO};
  assign term = (state == S_SHOW_OFF) ? TW'(GAP_TICKS) :
                (state == S_WAIT_IN) ? TW'(TIMEOUT_TICKS) : TW'(SHOW_TICKS);
  // Every timed exit is a state change, so a change of state restarts the tick count
  assign clr = (nxt != state);
  assign score = end_score(nxt == S_WIN, int'(len), DEPTH);
  assign BUSY = !(state inside {S_IDLE, S_WIN, S_LOSE});
  assign OUT_ENA = (state == S_SHOW_ON) || (state == S_ECHO);
  assign OUT = (state == S_SHOW_ON) ? seq[idx] : (state == S_ECHO) ? echo_q : '0;
  assign LEVEL = len;
  simon_tick_timer #(.TW(TW)) u_timer (
    .clk  (CLK),
    .rst_n(RST_N),
    .clr  (clr),
    .pulse(TIMER_PULSE && timed),
    .term (term),
    .done (done)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_WIN, S_LOSE: nxt = start_rise ? S_EXTEND : state;
      S_EXTEND: nxt = S_SHOW_ON;
      S_SHOW_ON: nxt = done ? S_SHOW_OFF : state;
      S_SHOW_OFF: nxt = !done ? state : last ? S_WAIT_IN : S_SHOW_ON;
      S_WAIT_IN: nxt = IN_VALID ? (hit ? S_ECHO : S_LOSE) : done ? S_LOSE : state;
      S_ECHO: nxt = !done ? state : !last ? S_WAIT_IN : full ? S_WIN : S_EXTEND;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= S_IDLE;
      start_q <= 1'b0;
      len <= '0;
      idx <= '0;
      best <= '0;
      echo_q <= '0;
      WIN <= 1'b0;
      LOSE <= 1'b0;
      HS <= 1'b0;
    end else begin
      state <= nxt;
      start_q <= START;
      if (!BUSY && start_rise) begin
        len <= '0;
        WIN <= 1'b0;
        LOSE <= 1'b0;
        HS <= 1'b0;
      end
      if (state == S_EXTEND) begin
        len <= len + LW'(1);
        idx <= '0;
      end
      if (state == S_SHOW_OFF && done) idx <= last ? '0 : idx + IW'(1);
      if (state == S_WAIT_IN && IN_VALID) echo_q <= IN;
      if (state == S_ECHO && done && !last) idx <= idx + IW'(1);
      if (clr && (nxt == S_WIN || nxt == S_LOSE)) begin
        WIN <= (nxt == S_WIN);
        LOSE <= (nxt == S_LOSE);
        if (score > int'(best)) begin
          best <= LW'(score);
          HS <= 1'b1;
        end
      end
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) for (int i = 0; i < DEPTH; i++) seq[i] <= '0;
    else if (state == S_EXTEND)
      seq[len[IW-1:0]] <= (int'(RAND) >= NUM_BUTTONS) ? BW'(int'(RAND) - NUM_BUTTONS) : RAND;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: table-driven and randomized games against a game-rule model of the Simon core
module tb_simon_sequencer;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [1:0] IN = '0, RAND = '0, OUT;
  logic IN_VALID = 1'b0, TIMER_PULSE = 1'b0, START = 1'b0;
  logic OUT_ENA, WIN, LOSE, HS, BUSY;
  logic [2:0] LEVEL;
  int n_chk = 0, n_fail = 0, best_m = 0;
  typedef struct {
    logic [3:0][1:0] s;
    int mode;
    int lr;
    int lp;
    logic [1:0] bad;
    logic e_win, e_lose, e_hs;
    logic [2:0] e_lvl;
  } vec_t;
  vec_t tbl [6];
  simon_sequencer #(.NUM_BUTTONS(4), .DEPTH(4), .SHOW_TICKS(2), .GAP_TICKS(1), .TIMEOUT_TICKS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .RAND(RAND), .TIMER_PULSE(TIMER_PULSE),
    .START(START), .OUT(OUT), .OUT_ENA(OUT_ENA), .WIN(WIN), .LOSE(LOSE), .HS(HS), .LEVEL(LEVEL), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) step();
      TIMER_PULSE = 1'b1;
      step();
      TIMER_PULSE = 1'b0;
    end
  endtask
  task automatic press(input logic [1:0] b);
    IN = b;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_ena", OUT_ENA, 0);
    chk("rst_busy", BUSY, 0);
    step();
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask
  function automatic vec_t mkv(input int a, b, c, d, mode, lr, lp, bad, w, l, h, lvl);
    vec_t v;
    v.s[0] = 2'(a); v.s[1] = 2'(b); v.s[2] = 2'(c); v.s[3] = 2'(d);
    v.mode = mode; v.lr = lr; v.lp = lp; v.bad = 2'(bad);
    v.e_win = 1'(w); v.e_lose = 1'(l); v.e_hs = 1'(h); v.e_lvl = 3'(lvl);
    return v;
  endfunction
  // mode 0: perfect play, 1: wrong press at (lr, lp), 2: timeout at (lr, lp)
  task automatic run_game(input vec_t v, input logic noise);
    int rounds;
    logic lost;
    rounds = (v.mode == 0) ? 4 : v.lr;
    lost = 1'b0;
    RAND = v.s[0];
    START = 1'b1;
    step();
    START = 1'b0;
    for (int r = 1; r <= rounds; r++) begin
      step();
      chk("level", LEVEL, r);
      for (int i = 0; i < r; i++) begin
        chk("show_out", OUT, v.s[i]);
        chk("show_ena", OUT_ENA, 1);
        pulses(2);
        chk("gap_dark", OUT_ENA, 0);
        if (noise) press(2'($urandom));
        pulses(1);
      end
      chk("wait_busy", BUSY, 1);
      if (r < 4) RAND = v.s[r];
      for (int i = 0; i < r; i++)
        if (!lost) begin
          if (v.mode != 0 && r == v.lr && i == v.lp) begin
            lost = 1'b1;
            if (v.mode == 1) press(v.bad);
            else begin
              pulses(7);
              chk("no_early_timeout", LOSE, 0);
              pulses(1);
            end
          end else begin
            press(v.s[i]);
            chk("echo_out", OUT, v.s[i]);
            chk("echo_ena", OUT_ENA, 1);
            pulses(2);
          end
        end
    end
    chk("end_win", WIN, v.e_win);
    chk("end_lose", LOSE, v.e_lose);
    chk("end_hs", HS, v.e_hs);
    chk("end_level", LEVEL, v.e_lvl);
    chk("end_busy", BUSY, 0);
    chk("end_ena", OUT_ENA, 0);
  endtask
  initial begin
    tbl[0] = mkv(1, 3, 0, 2, 1, 3, 2, 3, 0, 1, 1, 3);
    tbl[1] = mkv(2, 0, 1, 1, 1, 2, 0, 3, 0, 1, 0, 2);
    tbl[2] = mkv(3, 3, 2, 0, 2, 3, 1, 0, 0, 1, 0, 3);
    tbl[3] = mkv(1, 3, 0, 2, 0, 0, 0, 0, 1, 0, 1, 4);
    tbl[4] = mkv(0, 1, 2, 3, 0, 0, 0, 0, 1, 0, 0, 4);
    tbl[5] = mkv(2, 2, 2, 2, 1, 4, 3, 0, 0, 1, 0, 4);
    step();
    step();
    chk("reset_out", OUT, 0);
    chk("reset_ena", OUT_ENA, 0);
    chk("reset_win", WIN, 0);
    chk("reset_lose", LOSE, 0);
    chk("reset_hs", HS, 0);
    chk("reset_level", LEVEL, 0);
    chk("reset_busy", BUSY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    RAND = 2'd2;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("extend_busy", BUSY, 1);
    chk("extend_dark", OUT_ENA, 0);
    step();
    chk("first_out", OUT, 2);
    chk("first_ena", OUT_ENA, 1);
    chk("first_level", LEVEL, 1);
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    chk("start_ignored_ena", OUT_ENA, 1);
    chk("start_ignored_level", LEVEL, 1);
    pulses(1);
    chk("lit_after_1", OUT_ENA, 1);
    pulses(1);
    chk("dark_after_2", OUT_ENA, 0);
    pulses(1);
    RAND = 2'd3;
    press(2'd2);
    chk("a_echo_out", OUT, 2);
    pulses(2);
    step();
    chk("a_level2", LEVEL, 2);
    chk("a_show_ena", OUT_ENA, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_ena", OUT_ENA, 0);
    chk("midrst_out", OUT, 0);
    chk("midrst_level", LEVEL, 0);
    chk("midrst_busy", BUSY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    foreach (tbl[k]) run_game(tbl[k], 1'b0);
    RAND = 2'd1;
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    pulses(3);
    pulses(7);
    IN = 2'd1;
    IN_VALID = 1'b1;
    TIMER_PULSE = 1'b1;
    step();
    IN_VALID = 1'b0;
    TIMER_PULSE = 1'b0;
    chk("tie_no_lose", LOSE, 0);
    chk("tie_echo_ena", OUT_ENA, 1);
    chk("tie_echo_out", OUT, 1);
    do_reset();
    best_m = 0;
    for (int g = 0; g < 14; g++) begin
      vec_t v;
      int score;
      for (int i = 0; i < 4; i++) v.s[i] = 2'($urandom_range(0, 3));
      v.mode = $urandom_range(0, 2);
      v.lr = $urandom_range(1, 4);
      v.lp = $urandom_range(0, v.lr - 1);
      v.bad = v.s[v.lp] + 2'($urandom_range(1, 3));
      score = (v.mode == 0) ? 4 : v.lr - 1;
      v.e_win = (v.mode == 0);
      v.e_lose = (v.mode != 0);
      v.e_hs = (score > best_m);
      v.e_lvl = 3'((v.mode == 0) ? 4 : v.lr);
      if (score > best_m) best_m = score;
      run_game(v, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
